io_port_responder: RTL

Memory-mapped peripheral responder on the CPU data bus, selected when the upper address decode (address bit 7) routes an access away from data memory. It owns the board-facing I/O state: a latched 16-bit switch value, a 12-bit LED register, and two button-driven ready flags. It synchronises and debounces the two push-buttons and exposes a small register file the single-cycle CPU reads combinationally and writes on the clock edge. Its `switchl` and `led` outputs feed the 7-segment multiplexer.

---
 rtl/io_port_responder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/io_port_responder.sv
`default_nettype none
// ============================================================================
// Module   : io_port_responder
// Brief    : Bus-mapped switch/LED/button responder for the single-cycle CPU.
//            Define IO_DEBOUNCE_EN to build the counting button debouncer.
// Revision : 1.0
// ============================================================================
module io_port_responder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        bntL,
  input  logic        bntR,
  input  logic [15:0] switch,
  output logic [15:0] switchl,
  output logic [11:0] led
);

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_SWITCH = 2'd1;
  localparam logic [1:0] ADDR_LED    = 2'd2;
  localparam int         BTN_L       = 0;
  localparam int         BTN_R       = 1;

  logic [1:0]  btn_raw;
  logic [1:0]  sync1_q, sync1_d;
  logic [1:0]  sync2_q, sync2_d;
  logic [1:0]  edge_q, edge_d;
  logic [1:0]  level;
  logic [1:0]  press;
  logic [15:0] switchl_q, switchl_d;
  logic [11:0] led_q, led_d;
  logic        sw_ready_q, sw_ready_d;
  logic        led_ready_q, led_ready_d;
  logic        sw_read;
  logic        led_wr;
  logic        unused_bits;

  assign btn_raw = {bntR, bntL};

`ifdef IO_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]            deb_q, deb_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronised level disagrees with the accepted one.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] + 1'b1 == DEB_LIMIT) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_q <= '0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign level       = deb_q;
  assign unused_bits = ^wdata[31:12];
`else
  // Without the debouncer the edge register is the single registered copy of the level.
  assign level       = sync2_q;
  assign unused_bits = ^{wdata[31:12], 32'(DEBOUNCE_CYCLES), 32'(CNT_W)};
`endif

  assign press   = level & ~edge_q;
  assign sw_read = cs & ~we & (addr == ADDR_SWITCH);
  assign led_wr  = cs &  we & (addr == ADDR_LED);

  always_comb begin
    sync1_d     = btn_raw;
    sync2_d     = sync1_q;
    edge_d      = level;
    switchl_d   = switchl_q;
    sw_ready_d  = sw_ready_q;
    led_d       = led_q;
    led_ready_d = led_ready_q;
    // A fresh capture outranks a concurrent read; an LED write outranks an acknowledge.
    if (press[BTN_R]) begin
      switchl_d  = switch;
      sw_ready_d = 1'b1;
    end else if (sw_read) begin
      sw_ready_d = 1'b0;
    end
    if (led_wr) begin
      led_d       = wdata[11:0];
      led_ready_d = 1'b0;
    end else if (press[BTN_L]) begin
      led_ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      edge_q      <= '0;
      switchl_q   <= '0;
      sw_ready_q  <= 1'b0;
      led_q       <= '0;
      led_ready_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      edge_q      <= edge_d;
      switchl_q   <= switchl_d;
      sw_ready_q  <= sw_ready_d;
      led_q       <= led_d;
      led_ready_q <= led_ready_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (cs) begin
      case (addr)
        ADDR_STATUS: rdata = {30'b0, led_ready_q, sw_ready_q};
        ADDR_SWITCH: rdata = {16'b0, switchl_q};
        ADDR_LED:    rdata = {20'b0, led_q};
        default:     rdata = '0;
      endcase
    end
  end

  assign switchl = switchl_q;
  assign led     = led_q;

endmodule
`default_nettype wire
